stream_demux_3out: RTL

- One-input, three-output registered stream demultiplexer; the transmit-side counterpart of the 3-input selection mux.
- Steers each accepted input beat to one of three output channels, chosen by a 2-bit select.
- Every output channel has its own one-entry holding register with a valid/ready handshake.
- Used wherever one producer (writeback/forwarding path, bus slave port) must distribute words to three independent consumers that can stall.

---
 rtl/stream_demux_3out_if.sv | 41 ++++
 rtl/stream_demux_3out.sv | 84 ++++++++
 2 files changed

// File: rtl/stream_demux_3out_if.sv
// rtl/stream_demux_3out_if.sv - handshake bundle for the one-to-three stream demultiplexer
interface stream_demux_3out_if #(
    parameter int LENGTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] in_data;
    logic [1:0]        in_sel;

    logic              out1_valid;
    logic              out1_ready;
    logic [LENGTH-1:0] out1_data;

    logic              out2_valid;
    logic              out2_ready;
    logic [LENGTH-1:0] out2_data;

    logic              out3_valid;
    logic              out3_ready;
    logic [LENGTH-1:0] out3_data;

    // Producer/consumer side: drives the input beat and the channel ready signals.
    modport master (
        output in_valid, in_data, in_sel,
        output out1_ready, out2_ready, out3_ready,
        input  in_ready,
        input  out1_valid, out1_data,
        input  out2_valid, out2_data,
        input  out3_valid, out3_data
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel,
        input  out1_ready, out2_ready, out3_ready,
        output in_ready,
        output out1_valid, out1_data,
        output out2_valid, out2_data,
        output out3_valid, out3_data
    );
endinterface

// File: rtl/stream_demux_3out.sv
// rtl/stream_demux_3out.sv - registered 1-to-3 stream demux; STREAM_DEMUX_STATS_EN adds per-channel drain counters
module stream_demux_3out #(
    parameter int LENGTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef STREAM_DEMUX_STATS_EN
    output logic [47:0]          out_cnt,
`endif
    stream_demux_3out_if.slave   bus
);
    logic [2:0]        tgt_oh;
    logic [2:0]        rdy;
    logic [2:0]        valid_q;
    logic [LENGTH-1:0] data_q [3];
    logic [2:0]        load;
    logic [2:0]        drain;
    logic              accept;

    assign rdy = {bus.out3_ready, bus.out2_ready, bus.out1_ready};

    // Decode select into a one-hot target; selects 2 and 3 both map to channel 3.
    always_comb begin
        tgt_oh = 3'b000;
        case (bus.in_sel)
            2'd0:    tgt_oh = 3'b001;
            2'd1:    tgt_oh = 3'b010;
            default: tgt_oh = 3'b100;
        endcase
    end

    // A full target that is draining this cycle can still take the new beat.
    assign bus.in_ready = |(tgt_oh & (~valid_q | rdy));
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = tgt_oh & {3{accept}};
    assign drain        = valid_q & rdy;

    // Per-channel holding register: load wins over drain, drain alone only clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= bus.in_data;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.out1_valid = valid_q[0];
    assign bus.out1_data  = data_q[0];
    assign bus.out2_valid = valid_q[1];
    assign bus.out2_data  = data_q[1];
    assign bus.out3_valid = valid_q[2];
    assign bus.out3_data  = data_q[2];

`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0] cnt_q [3];

    // Count drain handshakes per channel; 16-bit counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'h0001;
                end
            end
        end
    end

    assign out_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule
